// File: rtl/trap_collector.sv
// Multi-channel trap collector: keeps the oldest outstanding trap by ROB age and delivers it at the ROB head.
// Optional perf counters (o_perf_replace, o_perf_deliver) are built when TRAP_COLLECT_PERF_EN is defined.
module trap_collector #(
  parameter int CHANNELS = 4,
  parameter int ROB_SIZE = 64,
  parameter int XLEN     = 64,
  parameter int CAUSE_W  = 16,
  localparam int RW      = 1 + $clog2(ROB_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       i_rpt_vld,
  input  logic [CHANNELS*RW-1:0]    i_rpt_robIdx,
  input  logic [CHANNELS*CAUSE_W-1:0] i_rpt_cause,
  input  logic [CHANNELS*XLEN-1:0]  i_rpt_epc,
  input  logic [CHANNELS*XLEN-1:0]  i_rpt_tval,
  input  logic                      i_squash_vld,
  input  logic [RW-1:0]             i_squash_robIdx,
  input  logic                      i_flush,
  input  logic [RW-1:0]             i_head_robIdx,
  input  logic                      i_trap_ack,
  output logic                      o_busy,
  output logic [RW-1:0]             o_trap_robIdx,
  output logic                      o_head_trap,
  output logic                      o_trap_vld,
  output logic [CAUSE_W-1:0]        o_trap_cause,
  output logic [XLEN-1:0]           o_trap_epc,
  output logic [XLEN-1:0]           o_trap_tval
`ifdef TRAP_COLLECT_PERF_EN
  ,
  output logic [31:0]               o_perf_replace,
  output logic [31:0]               o_perf_deliver
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;

  logic [1:0]         state, state_n;
  logic [RW-1:0]      held_idx;
  logic [CAUSE_W-1:0] held_cause;
  logic [XLEN-1:0]    held_epc;
  logic [XLEN-1:0]    held_tval;

  logic               win_vld;
  logic [RW-1:0]      win_idx;
  logic [CAUSE_W-1:0] win_cause;
  logic [XLEN-1:0]    win_epc;
  logic [XLEN-1:0]    win_tval;

  logic win_ok, held_ok, at_head;
  logic load, clear, cnt_replace, cnt_deliver;

  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
    else                    return a[RW-2:0] > b[RW-2:0];
  endfunction

  // Strictly-older replacement while scanning upward keeps the lowest channel on ties.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    win_cause = '0;
    win_epc   = '0;
    win_tval  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (i_rpt_vld[i] && (!win_vld || older(i_rpt_robIdx[i*RW +: RW], win_idx))) begin
        win_vld   = 1'b1;
        win_idx   = i_rpt_robIdx[i*RW +: RW];
        win_cause = i_rpt_cause[i*CAUSE_W +: CAUSE_W];
        win_epc   = i_rpt_epc[i*XLEN +: XLEN];
        win_tval  = i_rpt_tval[i*XLEN +: XLEN];
      end
    end
  end

  assign win_ok  = win_vld && !(i_squash_vld && older(i_squash_robIdx, win_idx));
  assign held_ok = !(i_squash_vld && older(i_squash_robIdx, held_idx));
  assign at_head = (state != IDLE) && (held_idx == i_head_robIdx);

  // A held trap at the head is the oldest live instruction, so moving to DELIVER
  // takes precedence over same-cycle squash and reports.
  always_comb begin
    state_n     = state;
    load        = 1'b0;
    clear       = 1'b0;
    cnt_replace = 1'b0;
    cnt_deliver = 1'b0;
    if (i_flush) begin
      state_n = IDLE;
      clear   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (win_ok) begin
            state_n = HOLD;
            load    = 1'b1;
          end
        end
        HOLD: begin
          if (at_head) begin
            state_n = DELIVER;
          end else if (held_ok) begin
            if (win_ok && older(win_idx, held_idx)) begin
              load        = 1'b1;
              cnt_replace = 1'b1;
            end
          end else if (win_ok) begin
            load        = 1'b1;
            cnt_replace = 1'b1;
          end else begin
            state_n = IDLE;
            clear   = 1'b1;
          end
        end
        DELIVER: begin
          if (i_trap_ack) begin
            state_n     = IDLE;
            clear       = 1'b1;
            cnt_deliver = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      held_idx   <= '0;
      held_cause <= '0;
      held_epc   <= '0;
      held_tval  <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        held_idx   <= '0;
        held_cause <= '0;
        held_epc   <= '0;
        held_tval  <= '0;
      end else if (load) begin
        held_idx   <= win_idx;
        held_cause <= win_cause;
        held_epc   <= win_epc;
        held_tval  <= win_tval;
      end
    end
  end

  assign o_busy        = (state != IDLE);
  assign o_trap_robIdx = held_idx;
  assign o_head_trap   = at_head;
  assign o_trap_vld    = (state == DELIVER);
  assign o_trap_cause  = o_trap_vld ? held_cause : '0;
  assign o_trap_epc    = o_trap_vld ? held_epc   : '0;
  assign o_trap_tval   = o_trap_vld ? held_tval  : '0;

`ifdef TRAP_COLLECT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_perf_replace <= '0;
      o_perf_deliver <= '0;
    end else begin
      if (cnt_replace) o_perf_replace <= o_perf_replace + 32'd1;
      if (cnt_deliver) o_perf_deliver <= o_perf_deliver + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_collector.sv
// Bench for trap_collector: directed scenarios plus randomized traffic against a modular-age reference model.
module tb_trap_collector;
  localparam int CH = 4;
  localparam int RS = 64;
  localparam int XL = 64;
  localparam int CW = 16;
  localparam int RW = 1 + $clog2(RS);
  localparam int M  = 2 * RS;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     rpt_vld;
  logic [CH*RW-1:0]  rpt_idx;
  logic [CH*CW-1:0]  rpt_cause;
  logic [CH*XL-1:0]  rpt_epc;
  logic [CH*XL-1:0]  rpt_tval;
  logic              sq_vld;
  logic [RW-1:0]     sq_idx;
  logic              flush;
  logic [RW-1:0]     head;
  logic              ack;
  logic              busy, head_trap, trap_vld;
  logic [RW-1:0]     trap_idx;
  logic [CW-1:0]     trap_cause;
  logic [XL-1:0]     trap_epc, trap_tval;
`ifdef TRAP_COLLECT_PERF_EN
  logic [31:0]       perf_replace, perf_deliver;
`endif

  trap_collector #(.CHANNELS(CH), .ROB_SIZE(RS), .XLEN(XL), .CAUSE_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rpt_vld(rpt_vld), .i_rpt_robIdx(rpt_idx), .i_rpt_cause(rpt_cause),
    .i_rpt_epc(rpt_epc), .i_rpt_tval(rpt_tval),
    .i_squash_vld(sq_vld), .i_squash_robIdx(sq_idx), .i_flush(flush),
    .i_head_robIdx(head), .i_trap_ack(ack),
    .o_busy(busy), .o_trap_robIdx(trap_idx), .o_head_trap(head_trap),
    .o_trap_vld(trap_vld), .o_trap_cause(trap_cause), .o_trap_epc(trap_epc),
    .o_trap_tval(trap_tval)
`ifdef TRAP_COLLECT_PERF_EN
    , .o_perf_replace(perf_replace), .o_perf_deliver(perf_deliver)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: age is the forward distance modulo 2*ROB_SIZE.
  bit            m_busy, m_dlv;
  logic [RW-1:0] m_idx;
  logic [CW-1:0] m_cause;
  logic [XL-1:0] m_epc, m_tval;
  logic [31:0]   m_rep, m_del;
  int            base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit m_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    int d;
    d = (int'(b) - int'(a) + M) % M;
    return (d >= 1) && (d < M / 2);
  endfunction

  task automatic m_reset();
    m_busy = 0; m_dlv = 0; m_idx = '0; m_cause = '0; m_epc = '0; m_tval = '0;
    m_rep = '0; m_del = '0;
  endtask

  task automatic m_clear();
    m_busy = 0; m_dlv = 0; m_idx = '0; m_cause = '0; m_epc = '0; m_tval = '0;
  endtask

  task automatic m_update();
    bit            w_vld, w_ok, h_ok;
    logic [RW-1:0] w_idx;
    int            w_ch;
    w_vld = 0; w_idx = '0; w_ch = 0;
    for (int i = 0; i < CH; i++)
      if (rpt_vld[i] && (!w_vld || m_older(rpt_idx[i*RW +: RW], w_idx))) begin
        w_vld = 1; w_idx = rpt_idx[i*RW +: RW]; w_ch = i;
      end
    w_ok = w_vld && !(sq_vld && m_older(sq_idx, w_idx));
    h_ok = !(sq_vld && m_older(sq_idx, m_idx));
    if (flush) m_clear();
    else if (!m_busy) begin
      if (w_ok) begin
        m_busy = 1; m_idx = w_idx; m_cause = rpt_cause[w_ch*CW +: CW];
        m_epc = rpt_epc[w_ch*XL +: XL]; m_tval = rpt_tval[w_ch*XL +: XL];
      end
    end else if (m_dlv) begin
      if (ack) begin m_clear(); m_del = m_del + 32'd1; end
    end else if (m_idx == head) m_dlv = 1;
    else if ((h_ok && w_ok && m_older(w_idx, m_idx)) || (!h_ok && w_ok)) begin
      m_idx = w_idx; m_cause = rpt_cause[w_ch*CW +: CW];
      m_epc = rpt_epc[w_ch*XL +: XL]; m_tval = rpt_tval[w_ch*XL +: XL];
      m_rep = m_rep + 32'd1;
    end else if (!h_ok) m_clear();
  endtask

  task automatic compare_model();
    check("busy", 64'(busy), 64'(m_busy));
    check("robidx", 64'(trap_idx), 64'(m_idx));
    check("head_trap", 64'(head_trap), 64'(m_busy && (m_idx == head)));
    check("trap_vld", 64'(trap_vld), 64'(m_dlv));
    check("cause", 64'(trap_cause), m_dlv ? 64'(m_cause) : 64'd0);
    check("epc", trap_epc, m_dlv ? m_epc : 64'd0);
    check("tval", trap_tval, m_dlv ? m_tval : 64'd0);
`ifdef TRAP_COLLECT_PERF_EN
    check("perf_replace", 64'(perf_replace), 64'(m_rep));
    check("perf_deliver", 64'(perf_deliver), 64'(m_del));
`endif
  endtask

  task automatic idle_in();
    rpt_vld = '0; rpt_idx = '0; rpt_cause = '0; rpt_epc = '0; rpt_tval = '0;
    sq_vld = 0; sq_idx = '0; flush = 0; head = '0; ack = 0;
  endtask

  task automatic set_rpt(input int ch, input logic [RW-1:0] idx, input logic [CW-1:0] c,
                         input logic [XL-1:0] e, input logic [XL-1:0] t);
    rpt_vld[ch] = 1'b1;
    rpt_idx[ch*RW +: RW] = idx;
    rpt_cause[ch*CW +: CW] = c;
    rpt_epc[ch*XL +: XL] = e;
    rpt_tval[ch*XL +: XL] = t;
  endtask

  // Called just after a negedge with inputs driven; ends at the next negedge with inputs idle.
  task automatic step();
    #1;
    compare_model();
    m_update();
    @(negedge clk);
    idle_in();
  endtask

  function automatic logic [RW-1:0] win_idx();
    return RW'((base + int'($urandom_range(0, 12))) % M);
  endfunction

  task automatic rand_in();
    for (int i = 0; i < CH; i++)
      if ($urandom % 4 == 0)
        set_rpt(i, win_idx(), CW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    sq_vld = ($urandom % 8 == 0);
    sq_idx = win_idx();
    flush  = ($urandom % 40 == 0);
    ack    = $urandom[0];
    head   = ($urandom % 3 == 0) ? m_idx : win_idx();
  endtask

  logic [31:0] saved;

  initial begin
    rst = 1'b1;
    idle_in();
    m_reset();
    base = 0;
    saved = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_vld", 64'(trap_vld), 64'd0);
    check("reset_idx", 64'(trap_idx), 64'd0);

    // Single report through delivery and ack
    set_rpt(2, 7'd10, 16'd5, 64'h8000_0100, 64'h1234);
    step();
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_idx", 64'(trap_idx), 64'd10);
    head = 7'd10;
    #1 check("s1_head", 64'(head_trap), 64'd1);
    step();
    check("s1_vld", 64'(trap_vld), 64'd1);
    check("s1_cause", 64'(trap_cause), 64'd5);
    check("s1_epc", trap_epc, 64'h8000_0100);
    check("s1_tval", trap_tval, 64'h1234);
    ack = 1'b1;
    step();
    check("s1_idle", 64'(busy), 64'd0);

    // Same-cycle arbitration with a tie
    set_rpt(0, 7'd20, 16'd2, 64'h1, 64'h1);
    set_rpt(3, 7'd12, 16'd13, 64'h3, 64'h3);
    set_rpt(1, 7'd12, 16'd4, 64'h2, 64'h2);
    step();
    check("arb_idx", 64'(trap_idx), 64'd12);
    head = 7'd12;
    step();
    check("arb_cause", 64'(trap_cause), 64'd4);
    ack = 1'b1;
    step();

    // Wrap-around age compare
    set_rpt(1, 7'd60, 16'd1, 64'h60, 64'h0);
    step();
    set_rpt(0, 7'd67, 16'd2, 64'h67, 64'h0);
    step();
    check("wrap_keep", 64'(trap_idx), 64'd60);
    flush = 1'b1;
    step();
`ifdef TRAP_COLLECT_PERF_EN
    saved = perf_replace;
`endif
    set_rpt(0, 7'd67, 16'd2, 64'h67, 64'h0);
    step();
    set_rpt(2, 7'd60, 16'd1, 64'h60, 64'h0);
    step();
    check("wrap_replace", 64'(trap_idx), 64'd60);
`ifdef TRAP_COLLECT_PERF_EN
    check("wrap_perf", 64'(perf_replace), 64'(saved + 32'd1));
`endif
    flush = 1'b1;
    step();

    // Squash younger and older held traps
    set_rpt(0, 7'd30, 16'd3, 64'h30, 64'h0);
    step();
    sq_vld = 1'b1; sq_idx = 7'd25;
    step();
    check("sq_drop", 64'(busy), 64'd0);
    set_rpt(0, 7'd20, 16'd3, 64'h20, 64'h0);
    step();
    sq_vld = 1'b1; sq_idx = 7'd25;
    step();
    check("sq_keep_busy", 64'(busy), 64'd1);
    check("sq_keep_idx", 64'(trap_idx), 64'd20);
    flush = 1'b1;
    step();

    // Flush during DELIVER beats ack and a same-cycle report
    set_rpt(1, 7'd40, 16'd9, 64'h40, 64'h0);
    step();
    head = 7'd40;
    step();
    check("fl_vld", 64'(trap_vld), 64'd1);
`ifdef TRAP_COLLECT_PERF_EN
    saved = perf_deliver;
`endif
    flush = 1'b1; ack = 1'b1;
    set_rpt(0, 7'd5, 16'd1, 64'h5, 64'h0);
    step();
    check("fl_busy", 64'(busy), 64'd0);
    step();
    check("fl_nolatch", 64'(busy), 64'd0);
`ifdef TRAP_COLLECT_PERF_EN
    check("fl_perf", 64'(perf_deliver), 64'(saved));
`endif

    // Asynchronous reset between edges while holding
    set_rpt(3, 7'd33, 16'd7, 64'h33, 64'h0);
    step();
    check("ar_pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_idx", 64'(trap_idx), 64'd0);
    check("ar_vld", 64'(trap_vld), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with a slowly drifting age window
    base = 100;
    for (int n = 0; n < 4000; n++) begin
      if (n % 20 == 0) base = (base + int'($urandom_range(0, 8))) % M;
      rand_in();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
